clk_src_ctrl: RTL and testbench
===============================

# clk_src_ctrl

Sequencer for the FPGA system clock-source multiplexer. It debounces the raw clock-select request and checks that the external clock is toggling. It then switches the global clock mux (0 = on-board PLL, 1 = external clock) only while the system is held in reset, so the core never runs across a clock switch. It sits in the FPGA top beside the clock generator, runs on a free-running reference clock, and drives the mux select plus a reset request that is ORed into the system reset.

## Interface
- DebounceCycles, 16: consecutive stable synchronized samples required to accept a new select value
- HoldCycles, 64: cycles the reset request is held before the mux select changes
- SettleCycles, 256: cycles after a select change (and after reset) before the reset request is released
- TimeoutCycles, 1024: cycles without an external-clock toggle edge before the external clock is declared lost
- clk_sys_i  in  1  free-running reference clock; all logic is in this single domain
- rst_sys_i  in  1  reset, asynchronous, active-high
- sel_req_i  in  1  raw asynchronous select request from the board pin (0 = PLL, 1 = external)
- alt_clk_tgl_i  in  1  asynchronous toggle derived from the external clock (divided externally)
- mux_sel_o  out  1  registered select for the global clock mux
- sys_rst_req_o  out  1  registered, active-high; holds the system in reset
- busy_o  out  1  high in any state other than IDLE
- alt_clk_ok_o  out  1  external clock currently judged present
- fallback_o  out  1  sticky; a forced return to the PLL occurred because the external clock was lost

## Operation
- Synchronizers:
  - sel_req_i passes through a 2-flop synchronizer.
  - alt_clk_tgl_i passes through a 2-flop synchronizer plus an edge-detect flop. Any change of the synced value counts as an edge.
- Debounce:
  - sel_stable updates to the synced select only after DebounceCycles consecutive cycles that differ from sel_stable and agree with each other.
  - Any bounce restarts the count.
  - sel_stable resets to 0.
- Watchdog:
  - The counter clears on every edge.
  - On an edge, alt_clk_ok_o is set to 1.
  - When the counter reaches TimeoutCycles-1 with no edge, alt_clk_ok_o is cleared to 0 and the counter saturates.
- fallback_o:
  - Set when alt_clk_ok_o falls while mux_sel_o = 1.
  - Cleared when sel_stable = 0.
- Target: tgt = sel_stable & alt_clk_ok_o & ~fallback_o.
- FSM states: IDLE, DRAIN, SWITCH, SETTLE.
  - IDLE: sys_rst_req_o = 0. If tgt != mux_sel_o, go to DRAIN. tgt is evaluated only in IDLE.
  - DRAIN: sys_rst_req_o = 1. Count HoldCycles, then go to SWITCH.
  - SWITCH: one cycle. mux_sel_o <= tgt, re-sampled in this cycle. Go to SETTLE.
  - SETTLE: sys_rst_req_o = 1. Count SettleCycles, then go to IDLE.
- If tgt re-sampled in SWITCH equals the current mux_sel_o, mux_sel_o is unchanged and SETTLE still runs in full.
- Loss during DRAIN or SETTLE: the sequence completes unchanged. If fallback_o was set, the FSM re-enters DRAIN on the first IDLE cycle.
- Request changes during a sequence are not lost: sel_stable keeps tracking, and tgt is re-checked in IDLE.
- Reset (asynchronous, any state):
  - Outputs: mux_sel_o = 0, sys_rst_req_o = 1, busy_o = 1, alt_clk_ok_o = 0, fallback_o = 0.
  - State goes to SETTLE with its counter cleared.
  - After release, the system leaves reset on the PLL after SettleCycles.

## Timing
- Outputs are registered; there are no combinational input-to-output paths.
- Select request to sel_stable: 2 synchronizer cycles plus DebounceCycles.
- sel_stable change to DRAIN entry: 1 cycle. sys_rst_req_o rises on the DRAIN entry edge.
- mux_sel_o changes exactly HoldCycles+1 cycles after sys_rst_req_o rises.
- sys_rst_req_o falls exactly SettleCycles cycles after the mux_sel_o change.
- Watchdog:
  - alt_clk_ok_o rises 3 cycles after the input toggle.
  - alt_clk_ok_o falls TimeoutCycles cycles after the last detected edge.
  - fallback_o rises 1 cycle after alt_clk_ok_o falls.
- Counters are sized $clog2 of the respective parameter (minimum 1 bit) and must never wrap: DRAIN, SETTLE and debounce counters clear on state entry, and the watchdog saturates.

## Test plan
Parameters for all scenarios: DebounceCycles = 4, HoldCycles = 8, SettleCycles = 16, TimeoutCycles = 32.
- Reset release:
  - Stimulus: release rst_sys_i with sel_req_i = 0.
  - Response: mux_sel_o = 0 throughout; sys_rst_req_o = 1 for 16 cycles, then 0; busy_o falls with it.
- Clean switch to external:
  - Stimulus: toggle alt_clk_tgl_i every 4 cycles, then set sel_req_i = 1.
  - Response: sys_rst_req_o rises 7 cycles after the request; mux_sel_o goes to 1 nine cycles after that; sys_rst_req_o falls 16 cycles later.
- Bounce rejection:
  - Stimulus: sel_req_i pulses high for 3 cycles, twice.
  - Response: sel_stable and mux_sel_o stay 0; sys_rst_req_o stays 0.
- Loss while on external:
  - Stimulus: stop alt_clk_tgl_i.
  - Response: alt_clk_ok_o falls 32 cycles after the last edge; fallback_o = 1; the switch sequence returns mux_sel_o to 0.
  - Then drive sel_req_i to 0: fallback_o clears after debounce and mux_sel_o stays 0.
- Select without external clock:
  - Stimulus: sel_req_i = 1 with alt_clk_tgl_i static.
  - Response: no DRAIN; mux_sel_o = 0. Starting the toggles afterwards triggers the full switch to 1.
- Mid-sequence reset:
  - Stimulus: assert rst_sys_i during DRAIN and during SETTLE.
  - Response: mux_sel_o = 0 and sys_rst_req_o = 1 immediately; a fresh 16-cycle SETTLE runs after release.

Source files
------------

// File: rtl/clk_src_ctrl_if.sv
// Clock-source sequencer pin bundle.
//   sel_req_i      raw select request from the board pin (0 = PLL, 1 = external)
//   alt_clk_tgl_i  divided toggle derived from the external clock
//   mux_sel_o      global clock mux select
//   sys_rst_req_o  active-high request holding the system in reset
//   busy_o         sequencer is not idle
//   alt_clk_ok_o   external clock judged present
//   fallback_o     sticky: forced return to the PLL after external clock loss
// master drives the requests (board/bench side); slave is the sequencer.
interface clk_src_ctrl_if;
  logic sel_req_i;
  logic alt_clk_tgl_i;
  logic mux_sel_o;
  logic sys_rst_req_o;
  logic busy_o;
  logic alt_clk_ok_o;
  logic fallback_o;

  modport master (
    output sel_req_i,
    output alt_clk_tgl_i,
    input  mux_sel_o,
    input  sys_rst_req_o,
    input  busy_o,
    input  alt_clk_ok_o,
    input  fallback_o
  );

  modport slave (
    input  sel_req_i,
    input  alt_clk_tgl_i,
    output mux_sel_o,
    output sys_rst_req_o,
    output busy_o,
    output alt_clk_ok_o,
    output fallback_o
  );
endinterface

// File: rtl/clk_src_ctrl.sv
// Clock-source sequencer: debounces the select request, watches the external
// clock toggle, and changes the global clock mux only while the system is held
// in reset (IDLE -> DRAIN -> SWITCH -> SETTLE -> IDLE).
//   clk_sys_i  free-running reference clock (single domain)
//   rst_sys_i  asynchronous active-high reset
//   bus        clk_src_ctrl_if.slave: requests in, mux select / reset request /
//              status out, all registered
module clk_src_ctrl #(
  parameter int unsigned DebounceCycles = 16,
  parameter int unsigned HoldCycles     = 64,
  parameter int unsigned SettleCycles   = 256,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic           clk_sys_i,
  input  logic           rst_sys_i,
  clk_src_ctrl_if.slave  bus
);

  localparam int unsigned DebW    = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int unsigned HoldW   = (HoldCycles     > 1) ? $clog2(HoldCycles)     : 1;
  localparam int unsigned SettleW = (SettleCycles   > 1) ? $clog2(SettleCycles)   : 1;
  localparam int unsigned WdW     = (TimeoutCycles  > 1) ? $clog2(TimeoutCycles)  : 1;

  localparam logic [DebW-1:0]    DebLast    = DebW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0]   HoldLast   = HoldW'(HoldCycles - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);
  localparam logic [WdW-1:0]     WdLast     = WdW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_e;

  // Select synchronizer and debounce
  logic            sel_s1_q;
  logic            sel_s2_q;
  logic            sel_stable_q;
  logic [DebW-1:0] deb_cnt_q;

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sel_s1_q     <= 1'b0;
      sel_s2_q     <= 1'b0;
      sel_stable_q <= 1'b0;
      deb_cnt_q    <= '0;
    end else begin
      sel_s1_q <= bus.sel_req_i;
      sel_s2_q <= sel_s1_q;
      // A single-bit sample that differs from sel_stable necessarily agrees
      // with every other differing sample, so any equal sample is a bounce.
      if (sel_s2_q != sel_stable_q) begin
        if (deb_cnt_q == DebLast) begin
          sel_stable_q <= sel_s2_q;
          deb_cnt_q    <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DebW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // External-clock toggle synchronizer, edge detect and watchdog
  logic           tgl_s1_q;
  logic           tgl_s2_q;
  logic           tgl_s3_q;
  logic           alt_edge;
  logic [WdW-1:0] wd_cnt_q;
  logic           alt_ok_q;
  logic           alt_ok_dly_q;

  assign alt_edge = tgl_s2_q ^ tgl_s3_q;

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      tgl_s1_q     <= 1'b0;
      tgl_s2_q     <= 1'b0;
      tgl_s3_q     <= 1'b0;
      wd_cnt_q     <= '0;
      alt_ok_q     <= 1'b0;
      alt_ok_dly_q <= 1'b0;
    end else begin
      tgl_s1_q     <= bus.alt_clk_tgl_i;
      tgl_s2_q     <= tgl_s1_q;
      tgl_s3_q     <= tgl_s2_q;
      alt_ok_dly_q <= alt_ok_q;
      if (alt_edge) begin
        wd_cnt_q <= '0;
        alt_ok_q <= 1'b1;
      end else if (wd_cnt_q == WdLast) begin
        // Saturate: the counter holds here until the next edge.
        alt_ok_q <= 1'b0;
      end else begin
        wd_cnt_q <= wd_cnt_q + WdW'(1);
      end
    end
  end

  // Sticky fallback: external clock dropped while the mux was on it
  logic fallback_q;
  logic mux_sel_q;

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      fallback_q <= 1'b0;
    end else if (!sel_stable_q) begin
      fallback_q <= 1'b0;
    end else if (alt_ok_dly_q && !alt_ok_q && mux_sel_q) begin
      fallback_q <= 1'b1;
    end
  end

  // Mux target; the FSM only looks at it in IDLE and SWITCH
  logic tgt;
  assign tgt = sel_stable_q & alt_ok_q & ~fallback_q;

  // Switch sequencer with registered outputs
  state_e             state_q;
  logic [HoldW-1:0]   hold_cnt_q;
  logic [SettleW-1:0] settle_cnt_q;
  logic               sys_rst_req_q;
  logic               busy_q;

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q       <= SETTLE;
      hold_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      mux_sel_q     <= 1'b0;
      sys_rst_req_q <= 1'b1;
      busy_q        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (tgt != mux_sel_q) begin
            state_q       <= DRAIN;
            hold_cnt_q    <= '0;
            sys_rst_req_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        DRAIN: begin
          if (hold_cnt_q == HoldLast) begin
            state_q <= SWITCH;
          end else begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        SWITCH: begin
          // Target re-sampled here; an unchanged target still runs SETTLE.
          mux_sel_q    <= tgt;
          state_q      <= SETTLE;
          settle_cnt_q <= '0;
        end
        SETTLE: begin
          if (settle_cnt_q == SettleLast) begin
            state_q       <= IDLE;
            sys_rst_req_q <= 1'b0;
            busy_q        <= 1'b0;
          end else begin
            settle_cnt_q <= settle_cnt_q + SettleW'(1);
          end
        end
        default: begin
          state_q       <= SETTLE;
          settle_cnt_q  <= '0;
          sys_rst_req_q <= 1'b1;
          busy_q        <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mux_sel_o     = mux_sel_q;
  assign bus.sys_rst_req_o = sys_rst_req_q;
  assign bus.busy_o        = busy_q;
  assign bus.alt_clk_ok_o  = alt_ok_q;
  assign bus.fallback_o    = fallback_q;

endmodule

// File: tb/tb_clk_src_ctrl.sv
// Directed bench for clk_src_ctrl with small parameters
// (Debounce 4, Hold 8, Settle 16, Timeout 32).
module tb_clk_src_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic tgl_en;
  int   tgl_ph;

  clk_src_ctrl_if bus ();

  clk_src_ctrl #(
    .DebounceCycles(4),
    .HoldCycles    (8),
    .SettleCycles  (16),
    .TimeoutCycles (32)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n clock edges; sample point is 1 time unit after each edge.
  // While enabled, the external toggle flips on every 4th step.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tgl_en) begin
        tgl_ph++;
        if (tgl_ph == 4) begin
          tgl_ph = 0;
          bus.alt_clk_tgl_i = ~bus.alt_clk_tgl_i;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tgl_en = 1'b0;
    tgl_ph = 0;
    rst    = 1'b1;
    bus.sel_req_i     = 1'b0;
    bus.alt_clk_tgl_i = 1'b0;

    // Reset state
    tick(2);
    chk("rst_mux", bus.mux_sel_o, 1'b0);
    chk("rst_sysrst", bus.sys_rst_req_o, 1'b1);
    chk("rst_busy", bus.busy_o, 1'b1);
    chk("rst_ok", bus.alt_clk_ok_o, 1'b0);
    chk("rst_fb", bus.fallback_o, 1'b0);

    // Reset release: 16-cycle SETTLE on the PLL
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("rel_sysrst_hold", bus.sys_rst_req_o, 1'b1);
      chk("rel_mux", bus.mux_sel_o, 1'b0);
    end
    tick(1);
    chk("rel_sysrst_fall", bus.sys_rst_req_o, 1'b0);
    chk("rel_busy_fall", bus.busy_o, 1'b0);

    // Start external clock toggles; ok rises 3 cycles after the first toggle
    tgl_en = 1'b1;
    tgl_ph = 0;
    tick(6);
    chk("ok_before", bus.alt_clk_ok_o, 1'b0);
    tick(1);
    chk("ok_rise", bus.alt_clk_ok_o, 1'b1);
    tick(5);

    // Bounce rejection: two 3-cycle pulses
    for (int k = 0; k < 2; k++) begin
      bus.sel_req_i = 1'b1;
      tick(3);
      bus.sel_req_i = 1'b0;
      tick(3);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("bounce_sysrst", bus.sys_rst_req_o, 1'b0);
    end
    chk("bounce_mux", bus.mux_sel_o, 1'b0);

    // Clean switch to external
    bus.sel_req_i = 1'b1;
    tick(6);
    chk("sw_sysrst_pre", bus.sys_rst_req_o, 1'b0);
    tick(1);
    chk("sw_sysrst_rise", bus.sys_rst_req_o, 1'b1);
    chk("sw_busy", bus.busy_o, 1'b1);
    tick(8);
    chk("sw_mux_pre", bus.mux_sel_o, 1'b0);
    tick(1);
    chk("sw_mux_rise", bus.mux_sel_o, 1'b1);
    tick(15);
    chk("sw_settle_hold", bus.sys_rst_req_o, 1'b1);
    tick(1);
    chk("sw_sysrst_fall", bus.sys_rst_req_o, 1'b0);
    chk("sw_busy_fall", bus.busy_o, 1'b0);
    chk("sw_mux_kept", bus.mux_sel_o, 1'b1);

    // Loss while on external: one last toggle, then silence
    tgl_en = 1'b0;
    tick(8);
    chk("loss_ok_pre", bus.alt_clk_ok_o, 1'b1);
    bus.alt_clk_tgl_i = ~bus.alt_clk_tgl_i;
    tick(34);
    chk("loss_ok_hold", bus.alt_clk_ok_o, 1'b1);
    tick(1);
    chk("loss_ok_fall", bus.alt_clk_ok_o, 1'b0);
    chk("loss_fb_pre", bus.fallback_o, 1'b0);
    chk("loss_idle", bus.sys_rst_req_o, 1'b0);
    tick(1);
    chk("loss_fb_rise", bus.fallback_o, 1'b1);
    chk("loss_drain", bus.sys_rst_req_o, 1'b1);
    chk("loss_mux_pre", bus.mux_sel_o, 1'b1);
    tick(8);
    chk("loss_mux_hold", bus.mux_sel_o, 1'b1);
    tick(1);
    chk("loss_mux_fall", bus.mux_sel_o, 1'b0);
    tick(15);
    chk("loss_settle", bus.sys_rst_req_o, 1'b1);
    tick(1);
    chk("loss_sysrst_fall", bus.sys_rst_req_o, 1'b0);
    chk("loss_fb_sticky", bus.fallback_o, 1'b1);
    tick(3);
    chk("loss_no_redrain", bus.sys_rst_req_o, 1'b0);

    // Request back to PLL clears fallback after debounce
    bus.sel_req_i = 1'b0;
    tick(6);
    chk("fbclr_pre", bus.fallback_o, 1'b1);
    tick(1);
    chk("fbclr", bus.fallback_o, 1'b0);
    chk("fbclr_mux", bus.mux_sel_o, 1'b0);
    chk("fbclr_sysrst", bus.sys_rst_req_o, 1'b0);

    // Select with no external clock: nothing happens
    bus.sel_req_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("noclk_sysrst", bus.sys_rst_req_o, 1'b0);
    end
    chk("noclk_mux", bus.mux_sel_o, 1'b0);
    chk("noclk_ok", bus.alt_clk_ok_o, 1'b0);

    // Toggles start: full switch to external
    tgl_en = 1'b1;
    tgl_ph = 0;
    tick(7);
    chk("late_ok", bus.alt_clk_ok_o, 1'b1);
    chk("late_sysrst_pre", bus.sys_rst_req_o, 1'b0);
    tick(1);
    chk("late_sysrst_rise", bus.sys_rst_req_o, 1'b1);
    tick(8);
    chk("late_mux_pre", bus.mux_sel_o, 1'b0);
    tick(1);
    chk("late_mux_rise", bus.mux_sel_o, 1'b1);
    tick(15);
    chk("late_settle", bus.sys_rst_req_o, 1'b1);
    tick(1);
    chk("late_sysrst_fall", bus.sys_rst_req_o, 1'b0);

    // Reset during DRAIN (heading back to PLL, mux still 1)
    bus.sel_req_i = 1'b0;
    tick(7);
    chk("mdr_drain", bus.sys_rst_req_o, 1'b1);
    chk("mdr_mux_pre", bus.mux_sel_o, 1'b1);
    tick(2);
    rst = 1'b1;
    #1;
    chk("mdr_mux", bus.mux_sel_o, 1'b0);
    chk("mdr_sysrst", bus.sys_rst_req_o, 1'b1);
    chk("mdr_busy", bus.busy_o, 1'b1);
    chk("mdr_ok", bus.alt_clk_ok_o, 1'b0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("mdr_settle", bus.sys_rst_req_o, 1'b1);
    end
    tick(1);
    chk("mdr_sysrst_fall", bus.sys_rst_req_o, 1'b0);
    chk("mdr_mux_after", bus.mux_sel_o, 1'b0);

    // Reset during SETTLE (just after switching to external)
    bus.sel_req_i = 1'b1;
    tick(7);
    chk("mse_drain", bus.sys_rst_req_o, 1'b1);
    tick(9);
    chk("mse_mux_rise", bus.mux_sel_o, 1'b1);
    tick(4);
    rst = 1'b1;
    #1;
    chk("mse_mux", bus.mux_sel_o, 1'b0);
    chk("mse_sysrst", bus.sys_rst_req_o, 1'b1);
    chk("mse_busy", bus.busy_o, 1'b1);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("mse_settle", bus.sys_rst_req_o, 1'b1);
      chk("mse_mux_hold", bus.mux_sel_o, 1'b0);
    end
    tick(1);
    chk("mse_sysrst_fall", bus.sys_rst_req_o, 1'b0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
